// File: rtl/cryptoram_arb_pkg.sv
// Shared types and constants for the two-port crypto RAM arbiter.
package cryptoram_arb_pkg;

  localparam int unsigned NREQ   = 2;
  localparam int unsigned AW_DEF = 10;
  localparam int unsigned DW_DEF = 32;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    CLRSTART = 2'd1,
    CLRWAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/cryptoram_arb_if.sv
// Requester bus and RAM-side bus of the crypto RAM arbiter.
interface cryptoram_arb_if
  import cryptoram_arb_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned BW = DW / 8
);
  logic [NREQ-1:0]         req;
  logic [NREQ-1:0][BW-1:0] wr;
  logic [NREQ-1:0][AW-1:0] addr;
  logic [NREQ-1:0][DW-1:0] wdat;
  logic [NREQ-1:0]         gnt;
  logic [NREQ-1:0]         rvalid;
  logic [DW-1:0]           rdat;
  logic [NREQ-1:0]         rerr;

  logic [AW-1:0] ramaddr;
  logic          ramen;
  logic          ramrd;
  logic [BW-1:0] ramwr;
  logic [DW-1:0] ramwdat;
  logic [DW-1:0] ramrdat;
  logic          ramready;
  logic [1:0]    ramerror;
  logic          ramclren;

  modport slave (
    input  req, wr, addr, wdat, ramrdat, ramready, ramerror, ramclren,
    output gnt, rvalid, rdat, rerr, ramaddr, ramen, ramrd, ramwr, ramwdat
  );

  modport master (
    output req, wr, addr, wdat, ramrdat, ramready, ramerror, ramclren,
    input  gnt, rvalid, rdat, rerr, ramaddr, ramen, ramrd, ramwr, ramwdat
  );
endinterface

// File: rtl/cryptoram_arb_rr_arb2.sv
// Two-way round-robin selector; ptr remembers the last granted port.
module rr_arb2
  import cryptoram_arb_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] gnt,
  output logic            ptr
);

  always_comb begin
    gnt = '0;
    if (advance) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr ? 2'b01 : 2'b10;
        default: gnt = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)     ptr <= 1'b0;
    else if (|gnt) ptr <= gnt[1];
  end

endmodule

// File: rtl/cryptoram_arb.sv
// Two-port arbiter in front of a crypto RAM with a full-clear sequencer.
// Optional sticky error latch: define CRYPTORAM_ARB_ERRLATCH_EN.
module cryptoram_arb
  import cryptoram_arb_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned BW = DW / 8
)(
  input  logic                  clk,
  input  logic                  reset,
  cryptoram_arb_if.slave        bus,
  input  logic                  clr_req,
  output logic                  busy,
  input  logic                  errclr,
  output logic [1:0]            errsts,
  output logic                  ramclr
);

  state_t          state, state_d;
  logic            busy_q, busy_d;
  logic [NREQ-1:0] rd_q;
  logic            clren_q;
  logic            allow;
  logic            rr_ptr;
  logic [NREQ-1:0] gnt;
  logic            sel;

  // Grants only in RUN, outside a clear, with the RAM ready.
  assign allow = ~reset && (state == RUN) && ~busy_q && bus.ramready;

  rr_arb2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (bus.req),
    .advance (allow),
    .gnt     (gnt),
    .ptr     (rr_ptr)
  );

  assign bus.gnt = gnt;
  assign sel     = gnt[1];

  always_comb begin
    bus.ramen   = 1'b0;
    bus.ramrd   = 1'b0;
    bus.ramwr   = '0;
    bus.ramaddr = '0;
    bus.ramwdat = '0;
    if (|gnt) begin
      bus.ramen   = 1'b1;
      bus.ramaddr = AW'(bus.addr[sel]);
      bus.ramwr   = BW'(bus.wr[sel]);
      bus.ramwdat = DW'(bus.wdat[sel]);
      bus.ramrd   = ~|bus.wr[sel];
    end
  end

  // A read pending when reset arrives is dropped rather than reported.
  assign bus.rvalid = rd_q & {NREQ{~reset}};
  assign bus.rdat   = (|bus.rvalid) ? bus.ramrdat : '0;
  assign bus.rerr   = bus.rvalid & {NREQ{|bus.ramerror}};
  assign busy       = busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      busy_q  <= 1'b0;
      rd_q    <= '0;
      clren_q <= 1'b0;
    end else begin
      state   <= state_d;
      busy_q  <= busy_d;
      rd_q    <= gnt & {NREQ{bus.ramrd}};
      clren_q <= bus.ramclren;
    end
  end

  // Clear sequencing: wait out the read response, pulse, then track the engine.
  always_comb begin
    state_d = state;
    busy_d  = busy_q;
    ramclr  = 1'b0;
    unique case (state)
      RUN: begin
        if (~busy_q && clr_req)   busy_d  = 1'b1;
        else if (busy_q && ~|rd_q) state_d = CLRSTART;
      end
      CLRSTART: begin
        ramclr  = 1'b1;
        state_d = CLRWAIT;
      end
      CLRWAIT: begin
        if (~bus.ramclren && clren_q) begin
          state_d = RUN;
          busy_d  = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase
  end

`ifdef CRYPTORAM_ARB_ERRLATCH_EN
  // Set wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) errsts <= '0;
    else       errsts <= (errsts & ~{2{errclr}}) | (bus.ramerror & {2{|bus.rvalid}});
  end
`else
  logic unused_errclr;
  assign unused_errclr = errclr;
  assign errsts        = '0;
`endif

  // With both ports requesting, the last-granted port must lose.
  assert property (@(posedge clk) disable iff (reset)
    (bus.req == 2'b11 && gnt != 2'b00) |-> !gnt[rr_ptr]);

endmodule

// File: tb/tb_cryptoram_arb.sv
// Self-checking bench for cryptoram_arb: table-driven arbitration plus directed clear/error/reset sequences.
module tb_cryptoram_arb;
  import cryptoram_arb_pkg::*;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;

`ifdef CRYPTORAM_ARB_ERRLATCH_EN
  localparam logic [1:0] EL_EXP = 2'b01;
`else
  localparam logic [1:0] EL_EXP = 2'b00;
`endif

  typedef struct {
    logic [1:0] req;
    logic       rdy;
    logic [1:0] gnt;
  } vec_t;

  typedef struct {
    logic [1:0]  port_oh;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic       clk = 1'b0;
  logic       reset, clr_req, errclr;
  logic       busy, ramclr;
  logic [1:0] errsts;

  int n_cmp = 0;
  int n_bad = 0;
  logic mon_en = 1'b0;
  rsp_t sbq[$];
  rsp_t mon_e;
  vec_t tv[13];

  logic [31:0] mem [1024];
  logic [31:0] ram_q;

  always #5 clk = ~clk;

  cryptoram_arb_if #(.AW(AW), .DW(DW), .BW(BW)) bus ();

  cryptoram_arb #(.AW(AW), .DW(DW), .BW(BW)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .clr_req (clr_req),
    .busy    (busy),
    .errclr  (errclr),
    .errsts  (errsts),
    .ramclr  (ramclr)
  );

  function automatic logic [31:0] f(input logic [9:0] a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  // Behavioural RAM: one-cycle read latency, byte-lane writes.
  always @(posedge clk) begin
    if (reset) begin
      for (int a = 0; a < 1024; a++) mem[a] <= f(10'(a));
      ram_q <= '0;
    end else if (bus.ramen) begin
      if (bus.ramrd) ram_q <= mem[bus.ramaddr];
      for (int b = 0; b < 4; b++)
        if (bus.ramwr[b]) mem[bus.ramaddr][8*b +: 8] <= bus.ramwdat[8*b +: 8];
    end
  end
  assign bus.ramrdat = ram_q;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Scoreboard: every rvalid must match the oldest expected response.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.rvalid != 2'b00) begin
        if (sbq.size() == 0) begin
          chk("rvalid_unexpected", 64'(bus.rvalid), 64'(0));
        end else begin
          mon_e = sbq.pop_front();
          chk("rvalid_port", 64'(bus.rvalid), 64'(mon_e.port_oh));
          chk("rdat", 64'(bus.rdat), 64'(mon_e.data));
          chk("rerr", 64'(bus.rerr), 64'(mon_e.err ? mon_e.port_oh : 2'b00));
        end
      end else begin
        chk("rdat_idle", 64'(bus.rdat), 64'(0));
      end
    end
  end

  initial begin : main
    logic seen;
    tv[0]  = '{2'b11, 1'b1, 2'b10};
    tv[1]  = '{2'b11, 1'b1, 2'b01};
    tv[2]  = '{2'b11, 1'b1, 2'b10};
    tv[3]  = '{2'b11, 1'b1, 2'b01};
    tv[4]  = '{2'b11, 1'b0, 2'b00};
    tv[5]  = '{2'b11, 1'b0, 2'b00};
    tv[6]  = '{2'b11, 1'b0, 2'b00};
    tv[7]  = '{2'b11, 1'b1, 2'b10};
    tv[8]  = '{2'b01, 1'b1, 2'b01};
    tv[9]  = '{2'b01, 1'b1, 2'b01};
    tv[10] = '{2'b10, 1'b1, 2'b10};
    tv[11] = '{2'b11, 1'b1, 2'b01};
    tv[12] = '{2'b00, 1'b1, 2'b00};

    reset = 1'b1; clr_req = 1'b0; errclr = 1'b0;
    bus.req = '0; bus.wr = '0; bus.addr = '0; bus.wdat = '0;
    bus.ramready = 1'b1; bus.ramerror = 2'b00; bus.ramclren = 1'b0;

    // Reset state, with requests pending to show they are masked
    tick(); bus.req = 2'b11; mon_en = 1'b1;
    smp();
    chk("rst_gnt", 64'(bus.gnt), 64'(0));
    chk("rst_rvalid", 64'(bus.rvalid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ramclr", 64'(ramclr), 64'(0));
    chk("rst_errsts", 64'(errsts), 64'(0));
    chk("rst_ram", 64'({bus.ramen, bus.ramrd, bus.ramwr, bus.ramaddr, bus.ramwdat}), 64'(0));
    tick(); reset = 1'b0; bus.req = 2'b00;
    smp();

    // Round-robin, ramready stall and lone requesters
    for (int i = 0; i < 13; i++) begin
      logic [9:0] ea;
      tick();
      bus.req = tv[i].req; bus.wr = '0;
      bus.addr[0] = 10'(16 + i); bus.addr[1] = 10'(48 + i);
      bus.ramready = tv[i].rdy;
      smp();
      chk($sformatf("gnt_v%0d", i), 64'(bus.gnt), 64'(tv[i].gnt));
      if (tv[i].gnt != 2'b00) begin
        ea = tv[i].gnt[1] ? 10'(48 + i) : 10'(16 + i);
        chk($sformatf("ramaddr_v%0d", i), 64'(bus.ramaddr), 64'(ea));
        chk($sformatf("ramrd_v%0d", i), 64'(bus.ramrd), 64'(1));
        sbq.push_back('{tv[i].gnt, f(ea), 1'b0});
      end else begin
        chk($sformatf("ram_idle_v%0d", i),
            64'({bus.ramen, bus.ramrd, bus.ramwr, bus.ramaddr, bus.ramwdat}), 64'(0));
      end
    end
    bus.ramready = 1'b1;

    // Port 0 write then read-back of address 3
    tick(); bus.req = 2'b01; bus.wr[0] = 4'hF; bus.addr[0] = 10'd3;
    bus.wdat[0] = 32'hA5A5_A5A5; bus.wdat[1] = 32'h5A5A_0000;
    smp();
    chk("wr_gnt", 64'(bus.gnt), 64'(2'b01));
    chk("wr_ramwr", 64'(bus.ramwr), 64'(4'hF));
    chk("wr_ramwdat", 64'(bus.ramwdat), 64'(32'hA5A5_A5A5));
    chk("wr_ramrd", 64'(bus.ramrd), 64'(0));
    tick(); bus.wr[0] = 4'h0;
    smp();
    chk("rd_gnt", 64'(bus.gnt), 64'(2'b01));
    chk("rd_ramaddr", 64'(bus.ramaddr), 64'(3));
    sbq.push_back('{2'b01, 32'hA5A5_A5A5, 1'b0});
    tick(); bus.req = 2'b00;
    smp();
    tick(); smp();

    // Error flag on a read response, ignored outside rvalid, cleared by errclr
    tick(); bus.req = 2'b10; bus.addr[1] = 10'd5;
    smp(); sbq.push_back('{2'b10, f(10'd5), 1'b1});
    tick(); bus.req = 2'b00; bus.ramerror = 2'b01;
    smp(); chk("errsts_before", 64'(errsts), 64'(0));
    tick(); bus.ramerror = 2'b00;
    smp(); chk("errsts_set", 64'(errsts), 64'(EL_EXP));
    tick(); bus.ramerror = 2'b10;
    smp();
    tick(); bus.ramerror = 2'b00;
    smp(); chk("errsts_no_rvalid", 64'(errsts), 64'(EL_EXP));
    tick(); bus.req = 2'b10;
    smp(); sbq.push_back('{2'b10, f(10'd5), 1'b1});
    tick(); bus.req = 2'b00; bus.ramerror = 2'b01; errclr = 1'b1;
    smp();
    tick(); bus.ramerror = 2'b00; errclr = 1'b0;
    smp(); chk("errsts_set_prio", 64'(errsts), 64'(EL_EXP));
    tick(); errclr = 1'b1;
    smp();
    tick(); errclr = 1'b0;
    smp(); chk("errsts_clr", 64'(errsts), 64'(0));

    // Clear request with a port-1 read granted in the same cycle
    tick(); bus.req = 2'b10; bus.addr[1] = 10'd7; clr_req = 1'b1;
    smp();
    chk("clr_gnt_same", 64'(bus.gnt), 64'(2'b10));
    chk("clr_busy0", 64'(busy), 64'(0));
    sbq.push_back('{2'b10, f(10'd7), 1'b0});
    tick(); clr_req = 1'b0;
    smp();
    chk("clr_gnt_block", 64'(bus.gnt), 64'(0));
    chk("clr_busy1", 64'(busy), 64'(1));
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick(); smp();
      chk("clr_wait_gnt", 64'(bus.gnt), 64'(0));
      chk("clr_wait_busy", 64'(busy), 64'(1));
      if (ramclr) begin seen = 1'b1; break; end
    end
    chk("clr_ramclr_seen", 64'(seen), 64'(1));
    tick(); bus.ramclren = 1'b1; clr_req = 1'b1;
    smp();
    chk("clr_pulse_end", 64'(ramclr), 64'(0));
    chk("clr_cw_busy", 64'(busy), 64'(1));
    chk("clr_cw_gnt", 64'(bus.gnt), 64'(0));
    tick(); smp();
    chk("clr_cw_busy2", 64'(busy), 64'(1));
    tick(); bus.ramclren = 1'b0;
    smp();
    chk("clr_exit_busy", 64'(busy), 64'(1));
    chk("clr_exit_gnt", 64'(bus.gnt), 64'(0));
    tick(); clr_req = 1'b0;
    smp();
    chk("clr_run_busy", 64'(busy), 64'(0));
    chk("clr_run_gnt", 64'(bus.gnt), 64'(2'b10));
    sbq.push_back('{2'b10, f(10'd7), 1'b0});
    tick(); bus.req = 2'b00;
    smp(); chk("clr_ignored_busy", 64'(busy), 64'(0));
    tick(); smp();
    chk("clr_ignored_busy2", 64'(busy), 64'(0));
    chk("clr_ignored_ramclr", 64'(ramclr), 64'(0));

    // Read pending at reset is dropped
    tick(); bus.req = 2'b01; bus.addr[0] = 10'd9;
    smp(); chk("drop_gnt", 64'(bus.gnt), 64'(2'b01));
    tick(); reset = 1'b1; bus.req = 2'b00;
    smp(); chk("drop_rvalid", 64'(bus.rvalid), 64'(0));
    tick(); reset = 1'b0;
    smp();

    // Reset while waiting on the clear engine
    tick(); clr_req = 1'b1;
    smp();
    tick(); clr_req = 1'b0;
    smp(); chk("cwr_busy", 64'(busy), 64'(1));
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick(); smp();
      if (ramclr) begin seen = 1'b1; break; end
    end
    chk("cwr_ramclr_seen", 64'(seen), 64'(1));
    tick(); bus.ramclren = 1'b1;
    smp(); chk("cwr_in_wait", 64'(busy), 64'(1));
    tick(); reset = 1'b1;
    smp();
    tick(); reset = 1'b0; bus.req = 2'b11; bus.addr[0] = 10'd30; bus.addr[1] = 10'd40;
    smp();
    chk("cwr_busy0", 64'(busy), 64'(0));
    chk("cwr_gnt", 64'(bus.gnt), 64'(2'b10));
    sbq.push_back('{2'b10, f(10'd40), 1'b0});
    tick(); bus.req = 2'b00; bus.ramclren = 1'b0;
    smp(); chk("cwr_busy_after", 64'(busy), 64'(0));
    tick(); smp();
    chk("cwr_ramclr_after", 64'(ramclr), 64'(0));

    tick(); smp();
    chk("sb_empty", 64'(sbq.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
